// File: rtl/alu_issue_scheduler_if.sv
// alu_issue_scheduler_if: request/response handshakes and ALU-side bus of the issue scheduler.
// The slave modport is the scheduler's view; master is the client/ALU environment's view.
interface alu_issue_scheduler_if;
  // Port 0 request
  logic        req0_valid;
  logic        req0_ready;
  logic        req0_wide;
  logic [63:0] req0_a;
  logic [63:0] req0_b;
  logic [2:0]  req0_op;
  logic [5:0]  req0_ctrl;
  // Port 1 request
  logic        req1_valid;
  logic        req1_ready;
  logic        req1_wide;
  logic [63:0] req1_a;
  logic [63:0] req1_b;
  logic [2:0]  req1_op;
  logic [5:0]  req1_ctrl;
  // Responses
  logic        rsp0_valid;
  logic        rsp0_ready;
  logic [63:0] rsp0_data;
  logic [2:0]  rsp0_flags;
  logic        rsp1_valid;
  logic        rsp1_ready;
  logic [63:0] rsp1_data;
  logic [2:0]  rsp1_flags;
  // Shared ALU
  logic [63:0] alu_a;
  logic [63:0] alu_b;
  logic        alu_mode;
  logic [2:0]  alu_opA;
  logic [2:0]  alu_opB;
  logic [5:0]  alu_ctrl;
  logic [63:0] alu_result;
  logic        alu_eqA;
  logic        alu_sltA;
  logic        alu_ultA;
  logic        alu_eqB;
  logic        alu_sltB;
  logic        alu_ultB;

  modport slave (
    input  req0_valid, req0_wide, req0_a, req0_b, req0_op, req0_ctrl,
    input  req1_valid, req1_wide, req1_a, req1_b, req1_op, req1_ctrl,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_flags,
    output rsp1_valid, rsp1_data, rsp1_flags,
    input  rsp0_ready, rsp1_ready,
    output alu_a, alu_b, alu_mode, alu_opA, alu_opB, alu_ctrl,
    input  alu_result, alu_eqA, alu_sltA, alu_ultA, alu_eqB, alu_sltB, alu_ultB
  );

  modport master (
    output req0_valid, req0_wide, req0_a, req0_b, req0_op, req0_ctrl,
    output req1_valid, req1_wide, req1_a, req1_b, req1_op, req1_ctrl,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_flags,
    input  rsp1_valid, rsp1_data, rsp1_flags,
    output rsp0_ready, rsp1_ready,
    input  alu_a, alu_b, alu_mode, alu_opA, alu_opB, alu_ctrl,
    output alu_result, alu_eqA, alu_sltA, alu_ultA, alu_eqB, alu_sltB, alu_ultB
  );
endinterface

// File: rtl/alu_issue_scheduler.sv
// alu_issue_scheduler: shares one combinational 64-bit split/unified ALU between two clients.
// Narrow port 0 rides lane A (low), narrow port 1 rides lane B (high); compatible narrow pairs
// issue together in split mode. Define ALU_SCHED_PERF_EN to add issue/pair perf counters.
module alu_issue_scheduler (
  input  logic        clk,
  input  logic        rst_n,
`ifdef ALU_SCHED_PERF_EN
  output logic [31:0] perf_issue_cnt,
  output logic [31:0] perf_pair_cnt,
`endif
  alu_issue_scheduler_if.slave bus
);

  typedef struct packed {
    logic        valid;
    logic        wide;
    logic [2:0]  op;
    logic [5:0]  ctrl;
    logic [63:0] a;
    logic [63:0] b;
  } ib_t;

  ib_t         ib0_q, ib0_d;
  ib_t         ib1_q, ib1_d;
  logic        rr_ptr_q, rr_ptr_d;

  logic        rsp0_valid_q, rsp0_valid_d;
  logic [63:0] rsp0_data_q, rsp0_data_d;
  logic [2:0]  rsp0_flags_q, rsp0_flags_d;
  logic        rsp1_valid_q, rsp1_valid_d;
  logic [63:0] rsp1_data_q, rsp1_data_d;
  logic [2:0]  rsp1_flags_q, rsp1_flags_d;

  logic        free0, free1;
  logic        qual0, qual1;
  logic        pair;
  logic        iss0, iss1;
  logic        ready0, ready1;
  logic [63:0] res0, res1;
  logic [2:0]  flg0, flg1;

  // Issue decision: pair when both narrow ops agree on ctrl, else round-robin single issue.
  always_comb begin
    free0 = !rsp0_valid_q || bus.rsp0_ready;
    free1 = !rsp1_valid_q || bus.rsp1_ready;
    qual0 = ib0_q.valid && free0;
    qual1 = ib1_q.valid && free1;
    pair  = qual0 && qual1 && !ib0_q.wide && !ib1_q.wide && (ib0_q.ctrl == ib1_q.ctrl);
    iss0  = 1'b0;
    iss1  = 1'b0;
    if (pair) begin
      iss0 = 1'b1;
      iss1 = 1'b1;
    end else if (qual0 && qual1) begin
      iss0 = !rr_ptr_q;
      iss1 = rr_ptr_q;
    end else begin
      iss0 = qual0;
      iss1 = qual1;
    end
    ready0 = !ib0_q.valid || iss0;
    ready1 = !ib1_q.valid || iss1;
  end

  // ALU operand routing; idle drives zeros in unified mode.
  always_comb begin
    bus.alu_a    = '0;
    bus.alu_b    = '0;
    bus.alu_mode = 1'b1;
    bus.alu_opA  = 3'b000;
    bus.alu_opB  = 3'b000;
    bus.alu_ctrl = '0;
    if (pair) begin
      bus.alu_mode = 1'b0;
      bus.alu_a    = {ib1_q.a[31:0], ib0_q.a[31:0]};
      bus.alu_b    = {ib1_q.b[31:0], ib0_q.b[31:0]};
      bus.alu_opA  = ib0_q.op;
      bus.alu_opB  = ib1_q.op;
      bus.alu_ctrl = ib0_q.ctrl;
    end else if (iss0) begin
      bus.alu_ctrl = ib0_q.ctrl;
      bus.alu_opA  = ib0_q.op;
      if (ib0_q.wide) begin
        bus.alu_mode = 1'b1;
        bus.alu_a    = ib0_q.a;
        bus.alu_b    = ib0_q.b;
      end else begin
        bus.alu_mode = 1'b0;
        bus.alu_a    = {32'h0, ib0_q.a[31:0]};
        bus.alu_b    = {32'h0, ib0_q.b[31:0]};
      end
    end else if (iss1) begin
      bus.alu_ctrl = ib1_q.ctrl;
      if (ib1_q.wide) begin
        // Wide ops always use the unified datapath driven through lane A's op select.
        bus.alu_mode = 1'b1;
        bus.alu_a    = ib1_q.a;
        bus.alu_b    = ib1_q.b;
        bus.alu_opA  = ib1_q.op;
      end else begin
        bus.alu_mode = 1'b0;
        bus.alu_a    = {ib1_q.a[31:0], 32'h0};
        bus.alu_b    = {ib1_q.b[31:0], 32'h0};
        bus.alu_opB  = ib1_q.op;
      end
    end
  end

  // Result steering: narrow results are zero-extended from the port's own lane.
  always_comb begin
    flg0 = {bus.alu_eqA, bus.alu_sltA, bus.alu_ultA};
    if (ib0_q.wide) begin
      res0 = bus.alu_result;
    end else begin
      res0 = {32'h0, bus.alu_result[31:0]};
    end
    if (ib1_q.wide) begin
      res1 = bus.alu_result;
      flg1 = {bus.alu_eqA, bus.alu_sltA, bus.alu_ultA};
    end else begin
      res1 = {32'h0, bus.alu_result[63:32]};
      flg1 = {bus.alu_eqB, bus.alu_sltB, bus.alu_ultB};
    end
  end

  // Next state for input buffers, response registers and the round-robin pointer.
  always_comb begin
    ib0_d = ib0_q;
    if (iss0) begin
      ib0_d.valid = 1'b0;
    end
    if (bus.req0_valid && ready0) begin
      ib0_d = '{valid: 1'b1, wide: bus.req0_wide, op: bus.req0_op, ctrl: bus.req0_ctrl,
                a: bus.req0_a, b: bus.req0_b};
    end

    ib1_d = ib1_q;
    if (iss1) begin
      ib1_d.valid = 1'b0;
    end
    if (bus.req1_valid && ready1) begin
      ib1_d = '{valid: 1'b1, wide: bus.req1_wide, op: bus.req1_op, ctrl: bus.req1_ctrl,
                a: bus.req1_a, b: bus.req1_b};
    end

    rsp0_valid_d = rsp0_valid_q;
    rsp0_data_d  = rsp0_data_q;
    rsp0_flags_d = rsp0_flags_q;
    if (iss0) begin
      rsp0_valid_d = 1'b1;
      rsp0_data_d  = res0;
      rsp0_flags_d = flg0;
    end else if (bus.rsp0_ready) begin
      rsp0_valid_d = 1'b0;
    end

    rsp1_valid_d = rsp1_valid_q;
    rsp1_data_d  = rsp1_data_q;
    rsp1_flags_d = rsp1_flags_q;
    if (iss1) begin
      rsp1_valid_d = 1'b1;
      rsp1_data_d  = res1;
      rsp1_flags_d = flg1;
    end else if (bus.rsp1_ready) begin
      rsp1_valid_d = 1'b0;
    end

    // Pair issues leave the pointer alone; a single issue hands priority to the other port.
    rr_ptr_d = rr_ptr_q;
    if (iss0 && !iss1) begin
      rr_ptr_d = 1'b1;
    end else if (iss1 && !iss0) begin
      rr_ptr_d = 1'b0;
    end
  end

  // Client-facing outputs straight from state.
  always_comb begin
    bus.req0_ready = ready0;
    bus.req1_ready = ready1;
    bus.rsp0_valid = rsp0_valid_q;
    bus.rsp0_data  = rsp0_data_q;
    bus.rsp0_flags = rsp0_flags_q;
    bus.rsp1_valid = rsp1_valid_q;
    bus.rsp1_data  = rsp1_data_q;
    bus.rsp1_flags = rsp1_flags_q;
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ib0_q        <= '0;
      ib1_q        <= '0;
      rr_ptr_q     <= 1'b0;
      rsp0_valid_q <= 1'b0;
      rsp0_data_q  <= '0;
      rsp0_flags_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_data_q  <= '0;
      rsp1_flags_q <= '0;
    end else begin
      ib0_q        <= ib0_d;
      ib1_q        <= ib1_d;
      rr_ptr_q     <= rr_ptr_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_data_q  <= rsp0_data_d;
      rsp0_flags_q <= rsp0_flags_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_data_q  <= rsp1_data_d;
      rsp1_flags_q <= rsp1_flags_d;
    end
  end

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] issue_cnt_q, pair_cnt_q;

  // Perf counters: one count per ALU issue cycle, one per pair; both wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issue_cnt_q <= '0;
      pair_cnt_q  <= '0;
    end else begin
      if (iss0 || iss1) begin
        issue_cnt_q <= issue_cnt_q + 32'd1;
      end
      if (pair) begin
        pair_cnt_q <= pair_cnt_q + 32'd1;
      end
    end
  end

  assign perf_issue_cnt = issue_cnt_q;
  assign perf_pair_cnt  = pair_cnt_q;
`endif

endmodule

// File: tb/tb_alu_issue_scheduler.sv
// tb_alu_issue_scheduler: directed vectors plus multi-cycle sequences for alu_issue_scheduler.
// The bench supplies a behavioural split/unified ALU; expected values are hand-computed.
module tb_alu_issue_scheduler;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  alu_issue_scheduler_if bus ();

`ifdef ALU_SCHED_PERF_EN
  logic [31:0] perf_issue_cnt;
  logic [31:0] perf_pair_cnt;
`endif

  alu_issue_scheduler dut (
    .clk            (clk),
    .rst_n          (rst_n),
`ifdef ALU_SCHED_PERF_EN
    .perf_issue_cnt (perf_issue_cnt),
    .perf_pair_cnt  (perf_pair_cnt),
`endif
    .bus            (bus)
  );

  always #5 clk = ~clk;

  // ALU ops: 0 add, 1 sub, 2 and, 3 or, 4 xor.
  function automatic logic [63:0] alu64(input logic [2:0] op, input logic [63:0] a,
                                        input logic [63:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 64'h0;
    endcase
  endfunction

  function automatic logic [31:0] alu32(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b);
    case (op)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return a ^ b;
      default: return 32'h0;
    endcase
  endfunction

  // Behavioural combinational ALU.
  always_comb begin
    bus.alu_result = '0;
    bus.alu_eqA    = 1'b0;
    bus.alu_sltA   = 1'b0;
    bus.alu_ultA   = 1'b0;
    bus.alu_eqB    = 1'b0;
    bus.alu_sltB   = 1'b0;
    bus.alu_ultB   = 1'b0;
    if (bus.alu_mode) begin
      bus.alu_result = alu64(bus.alu_opA, bus.alu_a, bus.alu_b);
      bus.alu_eqA    = bus.alu_a == bus.alu_b;
      bus.alu_sltA   = $signed(bus.alu_a) < $signed(bus.alu_b);
      bus.alu_ultA   = bus.alu_a < bus.alu_b;
    end else begin
      bus.alu_result = {alu32(bus.alu_opB, bus.alu_a[63:32], bus.alu_b[63:32]),
                        alu32(bus.alu_opA, bus.alu_a[31:0], bus.alu_b[31:0])};
      bus.alu_eqA    = bus.alu_a[31:0] == bus.alu_b[31:0];
      bus.alu_sltA   = $signed(bus.alu_a[31:0]) < $signed(bus.alu_b[31:0]);
      bus.alu_ultA   = bus.alu_a[31:0] < bus.alu_b[31:0];
      bus.alu_eqB    = bus.alu_a[63:32] == bus.alu_b[63:32];
      bus.alu_sltB   = $signed(bus.alu_a[63:32]) < $signed(bus.alu_b[63:32]);
      bus.alu_ultB   = bus.alu_a[63:32] < bus.alu_b[63:32];
    end
  end

  typedef struct {
    logic        port;
    logic        wide;
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        exp_mode;
    logic [63:0] exp_alu_a;
    logic [5:0]  exp_ops;    // {opB, opA}
    logic [63:0] exp_data;
    logic [2:0]  exp_flags;  // {eq, slt, ult}
  } vec_t;

  vec_t vecs[6];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int port, input logic wide, input logic [2:0] op,
                       input logic [5:0] ctrl, input logic [63:0] a, input logic [63:0] b);
    if (port == 0) begin
      bus.req0_valid = 1'b1;
      bus.req0_wide  = wide;
      bus.req0_op    = op;
      bus.req0_ctrl  = ctrl;
      bus.req0_a     = a;
      bus.req0_b     = b;
    end else begin
      bus.req1_valid = 1'b1;
      bus.req1_wide  = wide;
      bus.req1_op    = op;
      bus.req1_ctrl  = ctrl;
      bus.req1_a     = a;
      bus.req1_b     = b;
    end
  endtask

  task automatic idle_reqs();
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic seen;

    vecs[0] = '{1'b0, 1'b1, 3'd0, 64'hA, 64'h5,
                1'b1, 64'hA, 6'o00, 64'hF, 3'b000};
    vecs[1] = '{1'b0, 1'b0, 3'd1, 64'hFFFF_FFFF_0000_0005, 64'h1234_0000_0000_0007,
                1'b0, 64'h5, 6'o01, 64'h0000_0000_FFFF_FFFE, 3'b011};
    vecs[2] = '{1'b1, 1'b0, 3'd2, 64'h0000_0000_F0F0_1234, 64'h0000_0000_0FF0_FFFF,
                1'b0, 64'hF0F0_1234_0000_0000, 6'o20, 64'h0000_0000_00F0_1234, 3'b010};
    vecs[3] = '{1'b1, 1'b1, 3'd3, 64'h8000_0000_0000_0000, 64'h1,
                1'b1, 64'h8000_0000_0000_0000, 6'o03, 64'h8000_0000_0000_0001, 3'b010};
    vecs[4] = '{1'b0, 1'b0, 3'd4, 64'h1234_5678, 64'h1234_5678,
                1'b0, 64'h1234_5678, 6'o04, 64'h0, 3'b100};
    vecs[5] = '{1'b1, 1'b0, 3'd1, 64'h3, 64'hFFFF_FFFF,
                1'b0, 64'h0000_0003_0000_0000, 6'o10, 64'h4, 3'b001};

    bus.req0_valid = 1'b0; bus.req0_wide = 1'b0; bus.req0_op = '0; bus.req0_ctrl = '0;
    bus.req0_a = '0; bus.req0_b = '0;
    bus.req1_valid = 1'b0; bus.req1_wide = 1'b0; bus.req1_op = '0; bus.req1_ctrl = '0;
    bus.req1_a = '0; bus.req1_b = '0;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;

    // Reset state
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check("rst_rsp0_valid", 64'(bus.rsp0_valid), 64'd0);
    check("rst_rsp1_valid", 64'(bus.rsp1_valid), 64'd0);
    check("rst_req0_ready", 64'(bus.req0_ready), 64'd1);
    check("rst_req1_ready", 64'(bus.req1_ready), 64'd1);
    check("rst_alu_mode", 64'(bus.alu_mode), 64'd1);
    check("rst_alu_a", bus.alu_a, 64'd0);
    check("rst_rsp0_data", bus.rsp0_data, 64'd0);
`ifdef ALU_SCHED_PERF_EN
    check("rst_perf_issue", 64'(perf_issue_cnt), 64'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single-op vectors: issue in N+1, response in N+2
    for (int i = 0; i < 6; i++) begin
      drive(int'(vecs[i].port), vecs[i].wide, vecs[i].op, 6'd0, vecs[i].a, vecs[i].b);
      step();
      idle_reqs();
      @(negedge clk);
      check($sformatf("v%0d_alu_mode", i), 64'(bus.alu_mode), 64'(vecs[i].exp_mode));
      check($sformatf("v%0d_alu_a", i), bus.alu_a, vecs[i].exp_alu_a);
      check($sformatf("v%0d_alu_ops", i), 64'({bus.alu_opB, bus.alu_opA}),
            64'(vecs[i].exp_ops));
      step();
      @(negedge clk);
      check($sformatf("v%0d_rsp_valid", i),
            64'(vecs[i].port ? bus.rsp1_valid : bus.rsp0_valid), 64'd1);
      check($sformatf("v%0d_rsp_data", i),
            vecs[i].port ? bus.rsp1_data : bus.rsp0_data, vecs[i].exp_data);
      check($sformatf("v%0d_rsp_flags", i),
            64'(vecs[i].port ? bus.rsp1_flags : bus.rsp0_flags), 64'(vecs[i].exp_flags));
      step();
    end

    // Pair issue: both narrow, same ctrl
    do_reset();
    drive(0, 1'b0, 3'd0, 6'd0, 64'hCCCC_DDDD, 64'h3333_4444);
    drive(1, 1'b0, 3'd4, 6'd0, 64'hAAAA_BBBB, 64'h1111_2222);
    step();
    idle_reqs();
    @(negedge clk);
    check("pair_alu_mode", 64'(bus.alu_mode), 64'd0);
    check("pair_alu_a", bus.alu_a, 64'hAAAA_BBBB_CCCC_DDDD);
    check("pair_alu_ops", 64'({bus.alu_opB, bus.alu_opA}), 64'(6'o40));
    step();
    @(negedge clk);
    check("pair_rsp_valids", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd3);
    check("pair_rsp0_data", bus.rsp0_data, 64'h0000_0000_0000_2221);
    check("pair_rsp1_data", bus.rsp1_data, 64'h0000_0000_BBBB_9999);
    check("pair_rsp_flags", 64'({bus.rsp1_flags, bus.rsp0_flags}), 64'(6'b010010));
`ifdef ALU_SCHED_PERF_EN
    check("pair_perf_pair", 64'(perf_pair_cnt), 64'd1);
    check("pair_perf_issue", 64'(perf_issue_cnt), 64'd1);
`endif
    step();

    // Ctrl mismatch: round-robin issues port 0 then port 1
    do_reset();
    drive(0, 1'b0, 3'd0, 6'd0, 64'h1, 64'h2);
    drive(1, 1'b0, 3'd0, 6'd1, 64'h10, 64'h20);
    step();
    idle_reqs();
    @(negedge clk);
    check("rr_first_alu_a", bus.alu_a, 64'h1);
    check("rr_req1_ready_blocked", 64'(bus.req1_ready), 64'd0);
    step();
    @(negedge clk);
    check("rr_rsp0", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd1);
    check("rr_rsp0_data", bus.rsp0_data, 64'h3);
    check("rr_second_alu_a", bus.alu_a, 64'h0000_0010_0000_0000);
    check("rr_second_ctrl", 64'(bus.alu_ctrl), 64'd1);
    step();
    @(negedge clk);
    check("rr_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
    check("rr_rsp1_data", bus.rsp1_data, 64'h30);
    step();

    // Backpressure on port 0 must not block port 1
    do_reset();
    bus.rsp0_ready = 1'b0;
    drive(0, 1'b1, 3'd0, 6'd0, 64'h1, 64'h1);
    step();
    drive(0, 1'b1, 3'd0, 6'd0, 64'h2, 64'h2);
    drive(1, 1'b1, 3'd0, 6'd0, 64'h5, 64'h6);
    @(negedge clk);
    check("bp_req0_ready_issuing", 64'(bus.req0_ready), 64'd1);
    step();
    idle_reqs();
    @(negedge clk);
    check("bp_req0_ready_full", 64'(bus.req0_ready), 64'd0);
    check("bp_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
    check("bp_rsp0_data", bus.rsp0_data, 64'h2);
    check("bp_port1_issue", bus.alu_a, 64'h5);
    step();
    @(negedge clk);
    check("bp_rsp1_valid", 64'(bus.rsp1_valid), 64'd1);
    check("bp_rsp1_data", bus.rsp1_data, 64'hB);
    check("bp_req0_ready_still", 64'(bus.req0_ready), 64'd0);
    step();
    step();
    @(negedge clk);
    check("bp_rsp0_hold", bus.rsp0_data, 64'h2);
    check("bp_rsp0_valid_hold", 64'(bus.rsp0_valid), 64'd1);
    step();
    bus.rsp0_ready = 1'b1;
    @(negedge clk);
    check("bp_release_issue", bus.alu_a, 64'h2);
    step();
    @(negedge clk);
    check("bp_second_rsp0", bus.rsp0_data, 64'h4);
    check("bp_second_rsp0_valid", 64'(bus.rsp0_valid), 64'd1);
    step();

    // Asynchronous reset with IB0, IB1, RR0 and RR1 all occupied
    do_reset();
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    drive(0, 1'b1, 3'd0, 6'd0, 64'h7, 64'h0);
    drive(1, 1'b1, 3'd0, 6'd0, 64'h8, 64'h0);
    step();
    idle_reqs();
    drive(0, 1'b1, 3'd0, 6'd0, 64'h9, 64'h0);
    step();
    idle_reqs();
    drive(1, 1'b1, 3'd0, 6'd0, 64'hA, 64'h0);
    step();
    idle_reqs();
    @(negedge clk);
    check("ar_pre_readys", 64'({bus.req1_ready, bus.req0_ready}), 64'd0);
    check("ar_pre_valids", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd3);
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("ar_rsp_valids", 64'({bus.rsp1_valid, bus.rsp0_valid}), 64'd0);
    check("ar_req_readys", 64'({bus.req1_ready, bus.req0_ready}), 64'd3);
    check("ar_alu_mode", 64'(bus.alu_mode), 64'd1);
    check("ar_rsp0_data", bus.rsp0_data, 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (bus.rsp0_valid || bus.rsp1_valid || !bus.alu_mode) seen = 1'b1;
    end
    check("ar_no_rsp_after", 64'(seen), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
